// File: rtl/operand_assembler_pkg.sv
// Shared types and default sizing for the operand assembler, which packs
// narrow bus words into wide divider operands.
package operand_assembler_pkg;

  localparam int DEF_BUS_W   = 8;
  localparam int DEF_OP_W    = 16;
  localparam int DEF_NUM_OPS = 2;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_ISSUE   = 1'b1
  } opState_e;

endpackage

// File: rtl/operand_assembler.sv
// Collects NUM_OPS operands of OP_W bits from a BUS_W-wide valid/ready word
// stream, then offers them to a downstream divider with start.
module operand_assembler
  import operand_assembler_pkg::*;
#(
  parameter int BUS_W     = DEF_BUS_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int NUM_OPS   = DEF_NUM_OPS,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [BUS_W-1:0]                          data_in,
  input  logic                                      data_valid,
  output logic                                      data_ready,
  input  logic                                      abort,
  input  logic                                      ready_for_input,
  output logic                                      start,
  output logic [NUM_OPS*OP_W-1:0]                   operands,
  output logic [$clog2(NUM_OPS*OP_W/BUS_W+1)-1:0]   word_count,
  output opState_e                                  dbgState
);

  localparam int WORDS_PER_OP = OP_W / BUS_W;
  localparam int TOTAL_WORDS  = NUM_OPS * WORDS_PER_OP;
  localparam int CNT_W        = $clog2(TOTAL_WORDS + 1);

  // Handshake: a word moves on a rising edge where data_valid && data_ready;
  // data_ready depends only on state, and an abort in COLLECT wins over it.

  opState_e               state;
  logic                   accept;
  logic                   lastWord;
  logic [TOTAL_WORDS-1:0] wordSel;

  // Bit offset of global word j inside the packed operand bus.
  function automatic int slotLo(input int j);
    int opIdx;
    int wIdx;
    opIdx = j / WORDS_PER_OP;
    wIdx  = j % WORDS_PER_OP;
    if (LSB_FIRST)
      return opIdx * OP_W + wIdx * BUS_W;
    else
      return opIdx * OP_W + (WORDS_PER_OP - 1 - wIdx) * BUS_W;
  endfunction

  assign data_ready = (state == ST_COLLECT);
  assign start      = (state == ST_ISSUE);
  assign dbgState   = state;
  assign accept     = data_ready && data_valid && !abort;
  assign lastWord   = (word_count == CNT_W'(TOTAL_WORDS - 1));

  always_comb begin
    wordSel = '0;
    for (int j = 0; j < TOTAL_WORDS; j++) begin
      wordSel[j] = accept && (word_count == CNT_W'(j));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_COLLECT;
      word_count <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (abort) begin
            word_count <= '0;
          end else if (accept) begin
            if (lastWord) begin
              state      <= ST_ISSUE;
              word_count <= '0;
            end else begin
              word_count <= word_count + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (ready_for_input) state <= ST_COLLECT;
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  // Operands are only touched in COLLECT, so they are frozen while offered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operands <= '0;
    end else if (state == ST_COLLECT && abort) begin
      operands <= '0;
    end else begin
      for (int j = 0; j < TOTAL_WORDS; j++) begin
        if (wordSel[j]) operands[slotLo(j) +: BUS_W] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_operand_assembler.sv
// Bench for operand_assembler: directed scenarios on three configurations plus
// a randomized run on the default configuration against a word-slot model.
module tb_operand_assembler;
  import operand_assembler_pkg::*;

  logic clk;

  // default configuration, MSB-first
  logic        aReset, aValid, aAbort, aRfi, aReady, aStart;
  logic [7:0]  aData;
  logic [31:0] aOps;
  logic [2:0]  aCnt;
  opState_e    aDbg;

  // shared stimulus for the LSB-first and 3x32-bit instances
  logic        bcReset, bcValid, bcAbort, bcRfi;
  logic [7:0]  bcData;
  logic        bReady, bStart, cReady, cStart;
  logic [31:0] bOps;
  logic [2:0]  bCnt;
  logic [95:0] cOps;
  logic [3:0]  cCnt;
  opState_e    bDbg, cDbg;

  int nAsserts = 0;
  int nFails   = 0;

  // reference model state for the randomized run
  bit          mIssue;
  int          mCnt;
  logic [31:0] mOps;
  int          sh;

  operand_assembler dutA (
    .clk(clk), .reset(aReset), .data_in(aData), .data_valid(aValid),
    .data_ready(aReady), .abort(aAbort), .ready_for_input(aRfi),
    .start(aStart), .operands(aOps), .word_count(aCnt), .dbgState(aDbg)
  );

  operand_assembler #(.LSB_FIRST(1'b1)) dutB (
    .clk(clk), .reset(bcReset), .data_in(bcData), .data_valid(bcValid),
    .data_ready(bReady), .abort(bcAbort), .ready_for_input(bcRfi),
    .start(bStart), .operands(bOps), .word_count(bCnt), .dbgState(bDbg)
  );

  operand_assembler #(.BUS_W(8), .OP_W(32), .NUM_OPS(3)) dutC (
    .clk(clk), .reset(bcReset), .data_in(bcData), .data_valid(bcValid),
    .data_ready(cReady), .abort(bcAbort), .ready_for_input(bcRfi),
    .start(cStart), .operands(cOps), .word_count(cCnt), .dbgState(cDbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic sendA(input logic [7:0] w);
    aData  = w;
    aValid = 1'b1;
    @(negedge clk);
    aValid = 1'b0;
  endtask

  task automatic sendBC(input logic [7:0] w);
    bcData  = w;
    bcValid = 1'b1;
    @(negedge clk);
    bcValid = 1'b0;
  endtask

  initial begin
    aReset = 1'b0; aValid = 1'b0; aAbort = 1'b0; aRfi = 1'b1; aData = '0;
    bcReset = 1'b0; bcValid = 1'b0; bcAbort = 1'b0; bcRfi = 1'b1; bcData = '0;
    repeat (2) @(negedge clk);

    check("rst_cnt", aCnt, 0);
    check("rst_start", aStart, 0);
    check("rst_ops", aOps, 0);
    check("rst_ready", aReady, 1);
    check("rst_state", aDbg, ST_COLLECT);
    aReset = 1'b1; bcReset = 1'b1;
    @(negedge clk);

    // basic MSB-first transaction, downstream always ready
    sendA(8'hAA); sendA(8'hBB);
    check("cnt_two", aCnt, 2);
    sendA(8'hCC); sendA(8'hDD);
    check("basic_start", aStart, 1);
    check("basic_ops", aOps, 32'hCCDD_AABB);
    check("basic_cnt", aCnt, 0);
    check("basic_ready", aReady, 0);
    @(negedge clk);
    check("basic_start_drop", aStart, 0);
    check("basic_ready_back", aReady, 1);
    check("basic_ops_hold", aOps, 32'hCCDD_AABB);

    // downstream stalls for 5 cycles; EE offered and abort pulsed meanwhile
    aRfi = 1'b0;
    sendA(8'h11); sendA(8'h22); sendA(8'h33); sendA(8'h44);
    aData = 8'hEE; aValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_start", aStart, 1);
      check("stall_ready", aReady, 0);
      check("stall_ops", aOps, 32'h3344_1122);
      aAbort = (i == 2);
      @(negedge clk);
    end
    aAbort = 1'b0; aRfi = 1'b1;
    @(negedge clk);
    check("stall_release_start", aStart, 0);
    check("stall_ee_not_taken", aCnt, 0);
    @(negedge clk);
    aValid = 1'b0;
    check("ee_taken_cnt", aCnt, 1);
    check("ee_taken_ops", aOps, 32'h3344_EE22);
    aAbort = 1'b1;
    @(negedge clk);
    aAbort = 1'b0;
    check("abort_clr_cnt", aCnt, 0);
    check("abort_clr_ops", aOps, 0);

    // abort overriding a simultaneous word
    sendA(8'h11); sendA(8'h22);
    aData = 8'h33; aValid = 1'b1; aAbort = 1'b1;
    @(negedge clk);
    aValid = 1'b0; aAbort = 1'b0;
    check("abort_cnt", aCnt, 0);
    check("abort_ops", aOps, 0);
    sendA(8'h44); sendA(8'h55); sendA(8'h66); sendA(8'h77);
    check("abort_after_ops", aOps, 32'h6677_4455);
    check("abort_after_start", aStart, 1);
    @(negedge clk);

    // asynchronous reset between edges, mid-transaction
    sendA(8'h01); sendA(8'h02);
    check("pre_rst_cnt", aCnt, 2);
    #1 aReset = 1'b0;
    #1;
    check("async_rst_cnt", aCnt, 0);
    check("async_rst_start", aStart, 0);
    check("async_rst_ops", aOps, 0);
    #2 aReset = 1'b1;
    @(negedge clk);
    sendA(8'h0A); sendA(8'h0B); sendA(8'h0C); sendA(8'h0D);
    check("post_rst_ops", aOps, 32'h0C0D_0A0B);
    check("post_rst_start", aStart, 1);
    @(negedge clk);

    // LSB-first instance
    sendBC(8'hAA); sendBC(8'hBB); sendBC(8'hCC); sendBC(8'hDD);
    check("lsb_ops", bOps, 32'hDDCC_BBAA);
    check("lsb_start", bStart, 1);
    check("wide_cnt_four", cCnt, 4);

    // three 32-bit operands
    bcReset = 1'b0;
    #1;
    check("wide_rst_ops", cOps, 0);
    #2 bcReset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 12; i++) sendBC(8'(i));
    check("wide_ops", cOps, 96'h090A0B0C_05060708_01020304);
    check("wide_start", cStart, 1);
    check("wide_cnt", cCnt, 0);

    // randomized traffic on the default instance
    mIssue = 1'b0; mCnt = 0; mOps = 32'h0C0D_0A0B;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_start", aStart, mIssue);
      check("rnd_ready", aReady, !mIssue);
      check("rnd_cnt", aCnt, mCnt);
      check("rnd_ops", aOps, mOps);
      aValid = ($urandom_range(0, 3) != 0);
      aData  = 8'($urandom_range(0, 255));
      aAbort = ($urandom_range(0, 15) == 0);
      aRfi   = ($urandom_range(0, 2) != 0);
      if (mIssue) begin
        if (aRfi) mIssue = 1'b0;
      end else if (aAbort) begin
        mCnt = 0;
        mOps = '0;
      end else if (aValid) begin
        // operand mCnt/2, MSB-first so word 0 of an operand is its high byte
        sh   = (mCnt / 2) * 16 + (1 - (mCnt % 2)) * 8;
        mOps = (mOps & ~(32'hFF << sh)) | (32'(aData) << sh);
        mCnt++;
        if (mCnt == 4) begin
          mCnt   = 0;
          mIssue = 1'b1;
        end
      end
      @(negedge clk);
    end
    aValid = 1'b0; aAbort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/operand_assembler.md
OPERAND_ASSEMBLER -- requirements
Module: operand_assembler

Interface
REQ-001 SHALL have parameter BUS_W, default 8, meaning width of one input bus word.
REQ-002 SHALL have parameter OP_W, default 16, meaning width of one operand; an integer multiple of BUS_W, at least BUS_W.
REQ-003 SHALL have parameter NUM_OPS, default 2, meaning operands per transaction (op 0 = dividend, op 1 = divisor), at least 1.
REQ-004 SHALL have parameter LSB_FIRST, default 0, meaning word order: 0 = most-significant word of each operand first, 1 = least-significant first.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port data_in, input, BUS_W, meaning the input bus word.
REQ-008 SHALL have port data_valid, input, 1, meaning data_in holds a word to transfer.
REQ-009 SHALL have port data_ready, output, 1, meaning the block accepts a word this cycle.
REQ-010 SHALL have port abort, input, 1, meaning discard the partially collected transaction.
REQ-011 SHALL have port ready_for_input, input, 1, meaning the downstream divider can take operands.
REQ-012 SHALL have port start, output, 1, meaning operands are complete and offered downstream.
REQ-013 SHALL have port operands, output, NUM_OPS*OP_W, meaning operand k occupies bits [k*OP_W +: OP_W].
REQ-014 SHALL have port word_count, output, clog2(NUM_OPS*OP_W/BUS_W + 1), meaning words accepted in the current transaction.

Function
REQ-015 SHALL implement a two-state FSM: COLLECT and ISSUE.
REQ-016 In COLLECT, data_ready SHALL be 1; in ISSUE, data_ready SHALL be 0.
REQ-017 A word SHALL be accepted exactly on a rising edge where data_valid and data_ready are both 1.
REQ-018 Accepted words SHALL fill op 0 completely, then op 1, and so on up to op NUM_OPS-1.
REQ-019 Within an operand, the first word SHALL land in the top BUS_W bits when LSB_FIRST=0, and in the bottom BUS_W bits when LSB_FIRST=1.
REQ-020 word_count SHALL increment by 1 per accepted word.
REQ-021 On acceptance of word NUM_OPS*OP_W/BUS_W, the FSM SHALL go to ISSUE, so start is 1 in the cycle after that edge; word_count SHALL reset to 0.
REQ-022 In ISSUE, start SHALL stay 1 until an edge with ready_for_input=1; the FSM SHALL then return to COLLECT and start SHALL drop the next cycle.
REQ-023 When OP_W=BUS_W and NUM_OPS=1, the first word SHALL complete the transaction directly.
REQ-024 operands SHALL be stable throughout ISSUE, and SHALL hold their values in COLLECT until overwritten word-by-word.
REQ-025 abort=1 in COLLECT SHALL clear word_count and operands, and SHALL override a simultaneous acceptance.
REQ-026 abort=1 in ISSUE SHALL be ignored.
REQ-027 data_valid in ISSUE SHALL be ignored; the sender holds its word until data_ready returns.

Reset
REQ-028 Reset low SHALL immediately force state COLLECT, word_count 0, operands 0 and start 0, independent of clk.
REQ-029 Reset asserted mid-transaction or during ISSUE SHALL discard all collected words; the next accepted word is word 0 of op 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default BUS_W, OP_W and NUM_OPS constants.
REQ-031 Words-per-operand and total-word counts SHALL be localparams derived from the parameters.
REQ-032 The datapath SHALL be a single module with no sub-modules; operand registers SHALL be written through a decoded word index.

Verification
REQ-033 Default parameters, LSB_FIRST=0, words AA, BB, CC, DD with ready_for_input=1 -> operands = CCDD_AABB, start = 1 for exactly one cycle, one cycle after DD is accepted.
REQ-034 LSB_FIRST=1, words AA, BB, CC, DD -> op0 = BBAA, op1 = DDCC.
REQ-035 ready_for_input=0 for 5 cycles after completion -> start held and operands stable for all 5 cycles; data_ready = 0; a word EE presented meanwhile is not accepted.
REQ-036 Words 11, 22, then abort together with data_valid on word 33, then 44, 55, 66, 77 -> 33 dropped, word_count 0 after abort, op0 = 4455, op1 = 6677.
REQ-037 Reset pulsed low for 3 ns, between clock edges, after two words -> word_count = 0, start = 0 and operands = 0 immediately; a fresh four-word transaction then completes correctly.
REQ-038 BUS_W=8, OP_W=32, NUM_OPS=3, twelve words 01 to 0C -> op0 = 01020304, op1 = 05060708, op2 = 090A0B0C.
